// File: rtl/siso_frame_rx.sv
// Serial frame receiver: start(1), DATA_W data bits LSB first, optional even parity, stop(0).
// Latency: a good word appears on dout/dout_valid at the edge that samples its stop bit.
// Backpressure: single holding register; a good frame arriving while it is full and not being accepted is dropped and sets sticky overrun.
module siso_frame_rx #(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              si,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_bit;
    logic              par_ok;

    // Even parity: data bits XOR parity bit must be zero.
    assign par_ok = (PARITY_EN == 0) || ((^shreg) == par_bit);
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (dout_valid && dout_ready)
                dout_valid <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (si)
                        state <= DATA;
                end
                DATA: begin
                    shreg <= {si, shreg[DATA_W-1:1]};
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1))
                        state <= (PARITY_EN != 0) ? PARITY : STOP;
                end
                PARITY: begin
                    par_bit <= si;
                    state   <= STOP;
                end
                STOP: begin
                    // The stop sample always returns to IDLE, so it can never start a frame.
                    state <= IDLE;
                    if (si)
                        frame_err <= 1'b1;
                    else if (!par_ok)
                        parity_err <= 1'b1;
                    else if (!dout_valid || dout_ready) begin
                        dout       <= shreg;
                        dout_valid <= 1'b1;
                    end else
                        overrun <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/siso_frame_rx.md
SISO_FRAME_RX -- requirements
Module: siso_frame_rx

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, giving the data bits per frame (legal range 2..16).
REQ-002 SHALL provide parameter PARITY_EN, default 1: 1 means an even-parity bit follows the data bits; 0 means no parity bit.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low (rst=0 sampled at a rising clk edge resets).
REQ-005 SHALL have port si, input, 1 bit: serial line driven by the upstream shift-register output, one bit per clock.
REQ-006 SHALL have port dout, output, DATA_W bits: received data word.
REQ-007 SHALL have port dout_valid, output, 1 bit: dout holds an unconsumed word.
REQ-008 SHALL have port dout_ready, input, 1 bit: consumer accepts dout when dout_valid=1 and dout_ready=1 at a rising edge.
REQ-009 SHALL have port parity_err, output, 1 bit: one-cycle pulse when a frame is rejected for bad parity.
REQ-010 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is rejected for a bad stop bit.
REQ-011 SHALL have port overrun, output, 1 bit: sticky flag set when a good frame is dropped because the holding register was full.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL use this line format: idle level 0; start bit 1; DATA_W data bits, LSB first; parity bit if PARITY_EN=1 (even: XOR of data bits and parity = 0); stop bit 0.
REQ-014 SHALL implement FSM states IDLE, DATA, PARITY and STOP, with one si sample per clock in every state.
REQ-015 SHALL transition IDLE->DATA at the edge where si=1 is sampled; it SHALL stay in IDLE while si=0.
REQ-016 SHALL shift si into the data register in DATA using a bit counter 0..DATA_W-1, and SHALL leave DATA after counter value DATA_W-1, going to PARITY if PARITY_EN=1, else to STOP.
REQ-017 SHALL sample the parity bit in PARITY and then go to STOP.
REQ-018 SHALL sample si in STOP and always return to IDLE on the next edge; the stop-bit value is never reinterpreted as a start bit.
REQ-019 SHALL treat a frame as good when stop=0 and parity is correct (or PARITY_EN=0).
REQ-020 SHALL assert frame_err for exactly the cycle after the STOP sample when stop=1, and discard that frame.
REQ-021 SHALL assert parity_err for exactly the cycle after the STOP sample when stop=0 and parity fails, and discard that frame; if both errors occur, only frame_err pulses.
REQ-022 SHALL give a good frame a latency of 1 cycle: dout and dout_valid update at the edge that samples the stop bit.
REQ-023 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-024 SHALL clear dout_valid at the edge where dout_valid=1 and dout_ready=1, unless a new good frame completes at that same edge.
REQ-025 SHALL, when a good frame completes at the same edge as an accept, load the new word and keep dout_valid=1 (no bubble, no overrun).
REQ-026 SHALL, when a good frame completes while dout_valid=1 and dout_ready=0, drop the new word, keep the old dout, and set overrun=1 until reset.
REQ-027 SHALL never change dout while dout_valid=0, except on a load.

Reset
REQ-028 SHALL, with rst=0 at an edge, force state=IDLE, bit counter=0, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0 and busy=0 from the next cycle.
REQ-029 SHALL, when reset is applied mid-frame, abandon the partial frame with no error pulse and no dout update.
REQ-030 SHALL ignore si while rst=0; after rst returns to 1, the first si=1 is a start bit.

Verification (DATA_W=8, PARITY_EN=1)
REQ-031 SHALL check the good frame: si = 1, 1,0,1,0,0,1,0,1, 0, 0 (0xA5, parity 0, stop 0) with dout_ready=0 -> dout=0xA5 and dout_valid=1 at the edge after the stop sample, held until dout_ready=1.
REQ-032 SHALL check parity error: the 0xA5 frame with parity bit 1 -> parity_err pulses 1 cycle, dout_valid stays 0, and busy=0 on the next cycle.
REQ-033 SHALL check framing error: the 0xA5 frame with stop bit 1, then line 0 -> frame_err pulses 1 cycle, and no new frame starts from that stop bit.
REQ-034 SHALL check overrun: 0xA5 then 0x3C back-to-back, dout_ready=0 -> dout=0xA5 and overrun=1; repeat with dout_ready=1 at the 0x3C completion edge -> dout=0x3C, dout_valid=1, overrun=0.
REQ-035 SHALL check reset mid-frame: rst=0 after 4 data bits -> busy=0 next cycle, no error pulses, dout=0; a following 0xA5 frame is received correctly.
